// File: rtl/adder_arbiter_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package adder_arbiter_seq_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble index width; a single-nibble operand still needs one bit.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/parallel_adder_4bit.sv
// Combinational 4-bit ripple-carry adder shared by both requesters.
module parallel_adder_4bit
    import adder_arbiter_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/adder_arbiter_seq.sv
// Two-requester arbiter that sequences wide additions through one 4-bit adder,
// one nibble per cycle, and returns the tagged result on a shared response bus.
module adder_arbiter_seq
    import adder_arbiter_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req0_valid,
    output logic                         req0_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req0_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req0_b,
    input  logic                         req0_cin,
    input  logic                         req1_valid,
    output logic                         req1_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req1_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req1_b,
    input  logic                         req1_cin,
    output logic                         rsp_valid,
    output logic                         rsp_id,
    output logic [NIBBLE_W*NIBBLES-1:0]  rsp_sum,
    output logic                         rsp_cout,
    output logic                         busy
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_q;
    logic               prio_q;
    logic               id_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       opa_q;
    logic [W-1:0]       opb_q;
    logic [W-1:0]       sum_q;
    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic               rsp_cout_q;
    logic [W-1:0]       rsp_sum_q;

    logic               grant_id;
    logic               accept;
    int unsigned        nib_base;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] add_s;
    logic               add_cout;
    logic [W-1:0]       sum_d;

    // A lone requester wins outright; on contention the rotating pointer decides.
    assign grant_id   = (req0_valid & req1_valid) ? prio_q : req1_valid;
    assign accept     = rst_n & (state_q == IDLE) & (req0_valid | req1_valid);
    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept & grant_id;
    assign busy       = (state_q != IDLE);

    // Select the current nibble and splice the adder result back into the sum.
    always_comb begin
        nib_base = NIBBLE_W * 32'(idx_q);
        nib_a    = opa_q[nib_base +: NIBBLE_W];
        nib_b    = opb_q[nib_base +: NIBBLE_W];
        sum_d    = sum_q;
        sum_d[nib_base +: NIBBLE_W] = add_s;
    end

    parallel_adder_4bit u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            id_q        <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            sum_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_cout_q  <= 1'b0;
            rsp_sum_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        opa_q   <= grant_id ? req1_a : req0_a;
                        opb_q   <= grant_id ? req1_b : req0_b;
                        carry_q <= grant_id ? req1_cin : req0_cin;
                        idx_q   <= '0;
                        id_q    <= grant_id;
                        prio_q  <= ~grant_id;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q   <= sum_d;
                    carry_q <= add_cout;
                    idx_q   <= idx_q + IDX_W'(1);
                    // Last nibble: publish the finished result as DONE is entered.
                    if (idx_q == LAST_IDX) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_sum_q   <= sum_d;
                        rsp_cout_q  <= add_cout;
                        rsp_id_q    <= id_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_arbiter_seq.sv
// Bench for adder_arbiter_seq: transaction-level model with per-cycle compare,
// directed literal scenarios and a randomized two-requester phase.
module tb_adder_arbiter_seq;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 4 * N;
    localparam int unsigned WP = W + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic         v0 = 1'b0, v1 = 1'b0, c0 = 1'b0, c1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         rdy0, rdy1, rsp_valid, rsp_id, rsp_cout, busy;
    logic [W-1:0] rsp_sum;

    logic         sv0 = 1'b0, sv1 = 1'b0, sc0 = 1'b0, sc1 = 1'b0;
    logic [3:0]   sa0 = '0, sb0 = '0, sa1 = '0, sb1 = '0;
    logic         srdy0, srdy1, s_rsp_valid, s_rsp_id, s_rsp_cout, s_busy;
    logic [3:0]   s_rsp_sum;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction-level model: busy countdown, priority bit, held response.
    int           m_cnt = 0;
    logic         m_prio = 1'b0;
    logic         m_rsp_valid = 1'b0, m_rsp_id = 1'b0, m_rsp_cout = 1'b0;
    logic [W-1:0] m_rsp_sum = '0;
    logic [W:0]   m_pend = '0;
    logic         m_pend_id = 1'b0;
    logic         m_acc0 = 1'b0, m_acc1 = 1'b0;

    always #5 clk = ~clk;

    adder_arbiter_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(rdy0), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
        .req1_valid(v1), .req1_ready(rdy1), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy)
    );

    adder_arbiter_seq #(.NIBBLES(1)) dut_n1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(sv0), .req0_ready(srdy0), .req0_a(sa0), .req0_b(sb0), .req0_cin(sc0),
        .req1_valid(sv1), .req1_ready(srdy1), .req1_a(sa1), .req1_b(sb1), .req1_cin(sc1),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_sum(s_rsp_sum), .rsp_cout(s_rsp_cout),
        .busy(s_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_ready(input logic which);
        if (!rst_n || m_cnt != 0) return 1'b0;
        if (v0 && v1) return which == m_prio;
        if (v0) return which == 1'b0;
        if (v1) return which == 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_prio = 1'b0; m_rsp_valid = 1'b0; m_rsp_id = 1'b0;
        m_rsp_cout = 1'b0; m_rsp_sum = '0; m_acc0 = 1'b0; m_acc1 = 1'b0;
    endtask

    task automatic take(input logic id);
        if (id) m_pend = WP'(a1) + WP'(b1) + WP'(c1);
        else    m_pend = WP'(a0) + WP'(b0) + WP'(c0);
        m_pend_id = id;
        m_prio    = ~id;
        m_cnt     = N + 1;
    endtask

    // Advance the model across one rising edge using the pre-edge inputs.
    task automatic model_edge();
        m_acc0 = 1'b0; m_acc1 = 1'b0; m_rsp_valid = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_cnt == 0) begin
            if (exp_ready(1'b0)) begin m_acc0 = 1'b1; take(1'b0); end
            else if (exp_ready(1'b1)) begin m_acc1 = 1'b1; take(1'b1); end
        end else begin
            m_cnt--;
            if (m_cnt == 1) begin
                m_rsp_valid = 1'b1;
                m_rsp_sum   = m_pend[W-1:0];
                m_rsp_cout  = m_pend[W];
                m_rsp_id    = m_pend_id;
            end
        end
    endtask

    task automatic compare();
        check("req0_ready", 32'(rdy0), 32'(exp_ready(1'b0)));
        check("req1_ready", 32'(rdy1), 32'(exp_ready(1'b1)));
        check("busy", 32'(busy), 32'(m_cnt != 0));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        check("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
        check("rsp_sum", 32'(rsp_sum), 32'(m_rsp_sum));
        check("rsp_cout", 32'(rsp_cout), 32'(m_rsp_cout));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic run_op_lit(input string tag, input logic id, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic cin,
                              input logic [W-1:0] exp_sum, input logic exp_cout);
        int   edges = 0;
        logic seen  = 1'b0;
        if (id) begin v1 = 1'b1; a1 = a; b1 = b; c1 = cin; end
        else    begin v0 = 1'b1; a0 = a; b0 = b; c0 = cin; end
        while (!seen && edges < 20) begin
            step();
            edges++;
            if (m_acc0) v0 = 1'b0;
            if (m_acc1) v1 = 1'b0;
            if (rsp_valid) begin
                seen = 1'b1;
                check({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
                check({tag, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
                check({tag, "_id"}, 32'(rsp_id), 32'(id));
                check({tag, "_latency"}, 32'(edges), 32'(N + 1));
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        step();
        check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nacc, nrsp, edges, rsp0_cyc, acc1_cyc;
        logic seen;
        int   rsp_ids[5];
        int   rsp_cycs[5];
        int   exp_ids[5] = '{0, 1, 0, 1, 0};

        // Reset held with both requesters already valid.
        v0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom); c0 = 1'($urandom);
        v1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
        #1;
        check("rst_req0_ready", 32'(rdy0), 32'd0);
        check("rst_req1_ready", 32'(rdy1), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_n1_busy", 32'(s_busy), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Sustained contention: ids alternate, one acceptance every N+2 cycles.
        nacc = 0; nrsp = 0;
        for (int k = 0; k < 60 && nrsp < 5; k++) begin
            step();
            if (m_acc0 || m_acc1) nacc++;
            if (m_acc0) begin
                if (nacc <= 3) begin a0 = W'($urandom); b0 = W'($urandom); c0 = 1'($urandom); end
                else v0 = 1'b0;
            end
            if (m_acc1) begin
                if (nacc <= 3) begin a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom); end
                else v1 = 1'b0;
            end
            if (rsp_valid) begin
                rsp_ids[nrsp]  = 32'(rsp_id);
                rsp_cycs[nrsp] = cyc;
                nrsp++;
            end
        end
        check("alt_rsp_count", 32'(nrsp), 32'd5);
        for (int i = 0; i < nrsp; i++) check("alt_id", 32'(rsp_ids[i]), 32'(exp_ids[i]));
        for (int i = 1; i < nrsp; i++) check("alt_spacing", 32'(rsp_cycs[i] - rsp_cycs[i-1]), 32'(N + 2));
        step();

        run_op_lit("basic", 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        run_op_lit("chain", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op_lit("cin",   1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);

        // req1 arrives while req0 is in flight and must wait for IDLE.
        v0 = 1'b1; a0 = 16'h4321; b0 = 16'h0F0F; c0 = 1'b0;
        step();
        if (m_acc0) v0 = 1'b0;
        step();
        step();
        v1 = 1'b1; a1 = 16'hABCD; b1 = 16'h1234; c1 = 1'b1;
        rsp0_cyc = -100; acc1_cyc = -1; seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            step();
            if (rsp_valid && !rsp_id) rsp0_cyc = cyc;
            if (rdy1 && acc1_cyc < 0) acc1_cyc = cyc;
            if (m_acc1) v1 = 1'b0;
            if (rsp_valid && rsp_id) begin
                seen = 1'b1;
                check("blk_sum", 32'(rsp_sum), 32'h0000BE02);
                check("blk_cout", 32'(rsp_cout), 32'd0);
            end
        end
        check("blk_seen", 32'(seen), 32'd1);
        check("blk_ready_gap", 32'(acc1_cyc - rsp0_cyc), 32'd1);
        step();

        // Reset mid-ADD with the requester still holding valid.
        v0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001; c0 = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_ready", 32'(rdy0), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_sum", 32'(rsp_sum), 32'd0);
        check("mid_rst_id", 32'(rsp_id), 32'd0);
        check("mid_rst_cout", 32'(rsp_cout), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (m_acc0) v0 = 1'b0;
            if (rsp_valid) begin
                seen = 1'b1;
                check("reacc_sum", 32'(rsp_sum), 32'h00000100);
                check("reacc_cout", 32'(rsp_cout), 32'd0);
                check("reacc_id", 32'(rsp_id), 32'd0);
            end
        end
        check("reacc_seen", 32'(seen), 32'd1);
        step();

        // Single-nibble instance.
        sv0 = 1'b1; sa0 = 4'hF; sb0 = 4'h1; sc0 = 1'b0;
        #1;
        check("n1_ready", 32'(srdy0), 32'd1);
        edges = 0; seen = 1'b0;
        while (!seen && edges < 10) begin
            step();
            edges++;
            if (edges == 1) sv0 = 1'b0;
            if (s_rsp_valid) begin
                seen = 1'b1;
                check("n1_sum", 32'(s_rsp_sum), 32'h0);
                check("n1_cout", 32'(s_rsp_cout), 32'd1);
                check("n1_id", 32'(s_rsp_id), 32'd0);
                check("n1_latency", 32'(edges), 32'd2);
            end
        end
        check("n1_seen", 32'(seen), 32'd1);
        step();
        check("n1_pulse", 32'(s_rsp_valid), 32'd0);

        // Randomized traffic from both requesters.
        for (int k = 0; k < 400; k++) begin
            step();
            if (m_acc0) v0 = 1'b0;
            if (m_acc1) v1 = 1'b0;
            if (!v0 && $urandom_range(0, 3) == 0) begin
                v0 = 1'b1;
                a0 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
                b0 = W'($urandom);
                c0 = 1'($urandom);
            end
            if (!v1 && $urandom_range(0, 3) == 0) begin
                v1 = 1'b1;
                a1 = W'($urandom);
                b1 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
                c1 = 1'($urandom);
            end
        end
        for (int k = 0; k < 40 && (v0 || v1 || m_cnt != 0); k++) begin
            step();
            if (m_acc0) v0 = 1'b0;
            if (m_acc1) v1 = 1'b0;
        end
        check("drain_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_arbiter_seq.md
# adder_arbiter_seq

Sequencer and arbiter that shares one 4-bit ripple-carry adder (`parallel_adder_4bit`) between two requesters. Each requester submits wide operands through a valid/ready handshake. The block adds them nibble by nibble over consecutive cycles, carrying between steps in a register. It returns the full-width sum and carry-out on a shared response bus, tagged with the requester id. It sits between client logic and the single adder instance, so several consumers can use the small adder without duplicating it.

## Interface
- NIBBLES, 4, operand width in nibbles; W = 4*NIBBLES; legal range 1..16
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  W  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1
- rsp_valid  out  1  one-cycle pulse: result available
- rsp_id  out  1  requester that owns the result
- rsp_sum  out  W  sum, a+b+cin mod 2^W
- rsp_cout  out  1  carry out of the top nibble
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states and transitions:
  - IDLE: if any reqN_valid is high, grant one requester and capture a, b and cin → ADD.
  - ADD: one nibble per cycle. After nibble NIBBLES-1 → DONE.
  - DONE: assert rsp_valid → IDLE.
- Handshake:
  - reqN_ready = (state==IDLE) && grantN. It is combinational from the valid inputs.
  - Acceptance occurs on an edge where valid&&ready is high.
  - The requester holds valid and its payload stable until accepted. Valid must never depend on ready.
- Arbitration:
  - A 1-bit priority pointer `prio` resets to 0.
  - If only one requester is valid, grant it.
  - If both are valid, grant `prio`.
  - On acceptance, prio <= ~granted_id, giving strict alternation under sustained load.
- Datapath on capture:
  - opA <= a, opB <= b, carry <= cin, idx <= 0, id <= granted.
- Datapath on each ADD cycle:
  - The adder sees opA[4idx+:4], opB[4idx+:4] and carry.
  - sum_reg[4idx+:4] <= adder s; carry <= adder cout; idx <= idx+1.
- On entering DONE:
  - rsp_sum <= sum_reg, rsp_cout <= carry, rsp_id <= id.
  - These values hold until the next DONE.
  - rsp_valid is high only in DONE.
- Width rules:
  - The sum wraps mod 2^W. Overflow is reported only through rsp_cout.
  - idx is clog2(NIBBLES) bits, minimum 1.
- New requests arriving while busy wait. ready stays low; nothing is dropped.
- Reset mid-operation:
  - Everything clears immediately, and the in-flight result is discarded with no rsp_valid.
  - A requester still holding valid is re-arbitrated from IDLE with prio=0.

## Timing
- Reset values: req0_ready=0, req1_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0, state=IDLE, prio=0.
- Latency: rsp_valid is high in the cycle following the (NIBBLES+1)th edge after the accepting edge.
  - Accept edge → NIBBLES ADD cycles → DONE cycle.
- Throughput: one operation per NIBBLES+2 cycles (IDLE, ADD×NIBBLES, DONE). There is no overlap between operations.
- ready is never high in ADD or DONE. A requester that is valid in the DONE cycle is accepted in the following IDLE cycle.
- The adder path is combinational within one cycle: nibble mux → ripple → sum_reg/carry.

## Structure
- Shared package contents:
  - State typedef enum {IDLE, ADD, DONE}.
  - Constant NIBBLE_W = 4.
- One sub-module: instantiate the existing `parallel_adder_4bit` unchanged as the datapath. The arbiter, FSM, nibble mux and registers live in `adder_arbiter_seq`.
- No additional sub-modules.

## Test plan
- Basic add: req0 with a=16'h1234, b=16'h1111, cin=0.
  - Expect rsp_sum=16'h2345, rsp_cout=0, rsp_id=0.
  - rsp_valid exactly one cycle, 5 edges after acceptance.
- Full carry chain and carry-in:
  - req1 with a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, id=1.
  - Then a=16'h0000, b=16'h0000, cin=1 → sum=16'h0001, cout=0.
- Simultaneous requests from reset:
  - Both valid → req0 granted first, then req1.
  - Sustained both-valid → ids alternate 0,1,0,1.
  - Each acceptance is 6 cycles apart.
- Busy blocking: req1 raised during req0's ADD.
  - req1_ready stays 0 until IDLE.
  - req1 is accepted the cycle after req0's rsp_valid.
  - Its payload is unchanged in the result.
- Reset mid-ADD: assert rst_n=0 during ADD of a 16'h00FF+16'h0001 operation.
  - All outputs are 0 immediately, with no rsp_valid.
  - After release with valid still held, the operation is reaccepted and returns sum=16'h0100.
- Parameter check: NIBBLES=1 with a=4'hF, b=4'h1 → sum=4'h0, cout=1, latency 2 edges.
